hazard_forward_unit: RTL and testbench

//  Parametrised decode-stage dependency checker for the pipelined processor.

---
 rtl/hazard_forward_unit_pkg.sv | 40 ++++
 rtl/hazard_forward_unit_if.sv | 47 ++++
 rtl/hazard_forward_unit_fwd_match.sv | 34 +++
 rtl/hazard_forward_unit.sv | 162 ++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hfu_pkg
// Description : Shared constants and types for the decode-stage hazard and
//               forwarding unit: default widths, instruction field slots,
//               opcode constants and the history entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package hfu_pkg;

    // Default configuration.
    localparam int HFU_INS_W     = 20;
    localparam int HFU_OP_W      = 5;
    localparam int HFU_REG_W     = 5;
    localparam int HFU_IMM_W     = 8;
    localparam int HFU_FWD_DEPTH = 2;

    // Register indices in the history are held at this width, so REG_W must
    // not exceed it. Narrower indices are zero-extended.
    localparam int HFU_REG_W_MAX = 8;

    // Field positions in units of REG_W from the LSB: {op, rd, ra, rb}.
    localparam int HFU_RB_SLOT = 0;
    localparam int HFU_RA_SLOT = 1;
    localparam int HFU_RD_SLOT = 2;

    // Opcodes with the MSB set select the immediate as operand B.
    localparam logic [HFU_OP_W-1:0] OP_NOP = 5'h00;
    localparam logic [HFU_OP_W-1:0] OP_LD  = 5'h10;
    localparam logic [HFU_OP_W-1:0] OP_ST  = 5'h11;

    typedef struct packed {
        logic                     valid;
        logic                     wr;
        logic                     is_ld;
        logic [HFU_REG_W_MAX-1:0] rd;
    } hist_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit_if
// Description : Instruction input and decoded-control output bundle.
//               slave  : the hazard/forward unit
//               master : the instruction source / downstream consumer
//   ins, ins_valid             -> unit
//   ins_ready, stall           <- unit (combinational)
//   mux_sel_a/b, imm_sel, Imm, mem_*_dec, RW_dec, op_dec, dec_valid
//                              <- unit (registered)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_forward_unit_if #(
    parameter int INS_W = 20,
    parameter int OP_W  = 5,
    parameter int REG_W = 5,
    parameter int IMM_W = 8,
    parameter int SEL_W = 2
);
    logic [INS_W-1:0] ins;
    logic             ins_valid;
    logic             ins_ready;
    logic             stall;
    logic [SEL_W-1:0] mux_sel_a;
    logic [SEL_W-1:0] mux_sel_b;
    logic             imm_sel;
    logic [IMM_W-1:0] Imm;
    logic             mem_en_dec;
    logic             mem_rw_dec;
    logic             mem_mux_sel_dec;
    logic [REG_W-1:0] RW_dec;
    logic [OP_W-1:0]  op_dec;
    logic             dec_valid;

    modport slave (
        input  ins, ins_valid,
        output ins_ready, stall, mux_sel_a, mux_sel_b, imm_sel, Imm,
               mem_en_dec, mem_rw_dec, mem_mux_sel_dec, RW_dec, op_dec, dec_valid
    );

    modport master (
        output ins, ins_valid,
        input  ins_ready, stall, mux_sel_a, mux_sel_b, imm_sel, Imm,
               mem_en_dec, mem_rw_dec, mem_mux_sel_dec, RW_dec, op_dec, dec_valid
    );
endinterface
`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : hfu_fwd_match
// Description : Combinational priority matcher. Returns the stage number
//               (1 = youngest) of the youngest valid, writing history entry
//               whose destination equals i_idx, or 0 if none matches.
//   i_idx  : operand register index (zero-extended)
//   i_hist : history, element 0 = stage 1
//   o_sel  : forwarding select
// Revision    : 1.0 - initial release
// ============================================================================
module hfu_fwd_match
    import hfu_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = 2
) (
    input  wire logic [HFU_REG_W_MAX-1:0]         i_idx,
    input  wire hist_entry_t [FWD_DEPTH-1:0]      i_hist,
    output logic [SEL_W-1:0]                      o_sel
);

    // Scan oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        o_sel = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (i_hist[k].valid && i_hist[k].wr && (i_hist[k].rd == i_idx)) begin
                o_sel = SEL_W'(k + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Decode-stage dependency checker. Decodes each accepted
//               instruction into registered operand/memory controls, tracks
//               the destinations of the last FWD_DEPTH issued instructions,
//               generates per-operand forwarding selects and stalls issue
//               for one cycle on a load-use hazard.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : hazard_forward_unit_if.slave (instruction in, decode out)
// Build option: ZERO_REG_EN - register 0 is hardwired zero and is never
//               forwarded from nor stalled on.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit
    import hfu_pkg::*;
#(
    parameter int INS_W     = HFU_INS_W,
    parameter int OP_W      = HFU_OP_W,
    parameter int REG_W     = HFU_REG_W,
    parameter int IMM_W     = HFU_IMM_W,
    parameter int FWD_DEPTH = HFU_FWD_DEPTH
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_forward_unit_if.slave bus
);

    localparam int c_SEL_W  = $clog2(FWD_DEPTH + 1);
    localparam int c_RB_LSB = HFU_RB_SLOT * REG_W;
    localparam int c_RA_LSB = HFU_RA_SLOT * REG_W;
    localparam int c_RD_LSB = HFU_RD_SLOT * REG_W;

    // Field extraction
    logic [OP_W-1:0]          w_op;
    logic [REG_W-1:0]         w_rd, w_ra, w_rb;
    logic [HFU_REG_W_MAX-1:0] w_rd_x, w_ra_x, w_rb_x;
    logic [IMM_W-1:0]         w_imm;
    logic                     w_imm_sel, w_is_ld, w_is_st, w_wr;

    assign w_op      = bus.ins[INS_W-1 -: OP_W];
    assign w_rd      = bus.ins[c_RD_LSB +: REG_W];
    assign w_ra      = bus.ins[c_RA_LSB +: REG_W];
    assign w_rb      = bus.ins[c_RB_LSB +: REG_W];
    assign w_imm     = bus.ins[IMM_W-1:0];
    assign w_rd_x    = HFU_REG_W_MAX'(w_rd);
    assign w_ra_x    = HFU_REG_W_MAX'(w_ra);
    assign w_rb_x    = HFU_REG_W_MAX'(w_rb);
    assign w_imm_sel = w_op[OP_W-1];
    assign w_is_ld   = (w_op == OP_W'(OP_LD));
    assign w_is_st   = (w_op == OP_W'(OP_ST));

`ifdef ZERO_REG_EN
    // A write to r0 is discarded, so it never becomes a forwarding or
    // load-use source; reads of r0 therefore always resolve to select 0.
    assign w_wr = ~w_is_st & (w_rd != '0);
`else
    assign w_wr = ~w_is_st;
`endif

    // History: element 0 is stage 1 (youngest)
    hist_entry_t [FWD_DEPTH-1:0] r_hist;
    hist_entry_t                 w_new;

    // Load-use detection against the youngest stage only; one bubble moves
    // the load to stage 2 where it can be forwarded.
    logic w_ld_prod, w_hit_a, w_hit_b, w_stall, w_accept;

    assign w_ld_prod = r_hist[0].valid & r_hist[0].wr & r_hist[0].is_ld;
    assign w_hit_a   = w_ld_prod & (r_hist[0].rd == w_ra_x);
    assign w_hit_b   = w_ld_prod & (r_hist[0].rd == w_rb_x) & ~w_imm_sel;
    // Gated by reset so a stall in progress drops in the reset cycle itself.
    assign w_stall   = ~reset & bus.ins_valid & (w_hit_a | w_hit_b);
    assign w_accept  = bus.ins_valid & ~w_stall;

    always_comb begin
        w_new = '0;
        if (w_accept) begin
            w_new.valid = 1'b1;
            w_new.wr    = w_wr;
            w_new.is_ld = w_is_ld;
            w_new.rd    = w_rd_x;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
        end else begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                r_hist[k] <= r_hist[k-1];
            end
            r_hist[0] <= w_new;
        end
    end

    // Forwarding selects
    logic [c_SEL_W-1:0] w_sel_a, w_sel_b;

    hfu_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(c_SEL_W)) u_match_a (
        .i_idx  (w_ra_x),
        .i_hist (r_hist),
        .o_sel  (w_sel_a)
    );

    hfu_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(c_SEL_W)) u_match_b (
        .i_idx  (w_rb_x),
        .i_hist (r_hist),
        .o_sel  (w_sel_b)
    );

    // Decode registers; held across bubbles except for the valid flag.
    logic [c_SEL_W-1:0] r_sel_a, r_sel_b;
    logic               r_imm_sel, r_mem_en, r_mem_rw, r_mem_mux, r_dec_valid;
    logic [IMM_W-1:0]   r_imm;
    logic [REG_W-1:0]   r_rw;
    logic [OP_W-1:0]    r_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_a     <= '0;
            r_sel_b     <= '0;
            r_imm_sel   <= 1'b0;
            r_imm       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_mux   <= 1'b0;
            r_rw        <= '0;
            r_op        <= '0;
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= w_accept;
            if (w_accept) begin
                r_sel_a   <= w_sel_a;
                r_sel_b   <= w_imm_sel ? '0 : w_sel_b;
                r_imm_sel <= w_imm_sel;
                r_imm     <= w_imm;
                r_mem_en  <= w_is_ld | w_is_st;
                r_mem_rw  <= w_is_st;
                r_mem_mux <= w_is_ld;
                r_rw      <= w_rd;
                r_op      <= w_op;
            end
        end
    end

    assign bus.stall           = w_stall;
    assign bus.ins_ready       = ~w_stall;
    assign bus.mux_sel_a       = r_sel_a;
    assign bus.mux_sel_b       = r_sel_b;
    assign bus.imm_sel         = r_imm_sel;
    assign bus.Imm             = r_imm;
    assign bus.mem_en_dec      = r_mem_en;
    assign bus.mem_rw_dec      = r_mem_rw;
    assign bus.mem_mux_sel_dec = r_mem_mux;
    assign bus.RW_dec          = r_rw;
    assign bus.op_dec          = r_op;
    assign bus.dec_valid       = r_dec_valid;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Directed self-checking bench for hazard_forward_unit at the
//               default configuration (FWD_DEPTH=2, 5-bit registers).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;
    import hfu_pkg::*;

    localparam logic [4:0] c_ADD  = 5'h01;
    localparam logic [4:0] c_SUB  = 5'h02;
    localparam logic [4:0] c_ADDI = 5'h18;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    int   n_fail;

    hazard_forward_unit_if #(.INS_W(20), .OP_W(5), .REG_W(5), .IMM_W(8), .SEL_W(2)) bus ();

    hazard_forward_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [19:0] i, input logic v);
        @(negedge clk);
        bus.ins       = i;
        bus.ins_valid = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle2();
        drive(20'h0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        reset         = 1'b1;
        bus.ins       = '0;
        bus.ins_valid = 1'b0;

        // 1. Reset state
        tick();
        tick();
        chk("rst_dec_valid", 32'(bus.dec_valid), 0);
        chk("rst_ins_ready", 32'(bus.ins_ready), 1);
        chk("rst_stall",     32'(bus.stall), 0);
        chk("rst_sel_a",     32'(bus.mux_sel_a), 0);
        chk("rst_rw",        32'(bus.RW_dec), 0);
        chk("rst_mem_en",    32'(bus.mem_en_dec), 0);
        chk("rst_op",        32'(bus.op_dec), 0);
        reset = 1'b0;

        drive(mk(c_ADD, 5'd2, 5'd1, 5'd3), 1'b1);
        chk("t1_ready", 32'(bus.ins_ready), 1);
        tick();
        chk("t1_valid", 32'(bus.dec_valid), 1);
        chk("t1_sel_a", 32'(bus.mux_sel_a), 0);
        chk("t1_sel_b", 32'(bus.mux_sel_b), 0);
        chk("t1_rw",    32'(bus.RW_dec), 2);
        chk("t1_op",    32'(bus.op_dec), 32'(c_ADD));
        chk("t1_mem",   32'(bus.mem_en_dec), 0);

        // 2. Back-to-back forwarding, stage 1 then stage 2
        drive(mk(c_ADD, 5'd4, 5'd1, 5'd2), 1'b1);
        tick();
        chk("t2a_sel_a", 32'(bus.mux_sel_a), 0);
        chk("t2a_sel_b", 32'(bus.mux_sel_b), 1);
        drive(mk(c_SUB, 5'd5, 5'd4, 5'd4), 1'b1);
        tick();
        chk("t2b_sel_a", 32'(bus.mux_sel_a), 1);
        chk("t2b_sel_b", 32'(bus.mux_sel_b), 1);
        drive(mk(c_ADD, 5'd7, 5'd4, 5'd9), 1'b1);
        tick();
        chk("t2c_sel_a", 32'(bus.mux_sel_a), 2);
        chk("t2c_sel_b", 32'(bus.mux_sel_b), 0);
        idle2();
        chk("idle_valid", 32'(bus.dec_valid), 0);
        chk("idle_hold",  32'(bus.RW_dec), 7);

        // 3. Load-use stall
        drive(mk(OP_LD, 5'd6, 5'd1, 5'd0), 1'b1);
        tick();
        chk("ld_mem_en", 32'(bus.mem_en_dec), 1);
        chk("ld_rw",     32'(bus.mem_rw_dec), 0);
        chk("ld_mux",    32'(bus.mem_mux_sel_dec), 1);
        chk("ld_rd",     32'(bus.RW_dec), 6);
        drive(mk(c_ADD, 5'd7, 5'd6, 5'd1), 1'b1);
        chk("lu_stall", 32'(bus.stall), 1);
        chk("lu_ready", 32'(bus.ins_ready), 0);
        tick();
        chk("lu_bubble", 32'(bus.dec_valid), 0);
        chk("lu_stall2", 32'(bus.stall), 0);
        chk("lu_ready2", 32'(bus.ins_ready), 1);
        tick();
        chk("lu_valid", 32'(bus.dec_valid), 1);
        chk("lu_sel_a", 32'(bus.mux_sel_a), 2);
        chk("lu_rw",    32'(bus.RW_dec), 7);
        idle2();

        // 4. Immediate operand: B select forced to 0, no stall through rb
        drive(mk(c_ADD, 5'd1, 5'd2, 5'd3), 1'b1);
        tick();
        drive(mk(c_ADDI, 5'd10, 5'd9, 5'd1), 1'b1);
        tick();
        chk("imm_sel",   32'(bus.imm_sel), 1);
        chk("imm_val",   32'(bus.Imm), 32'h21);
        chk("imm_sel_b", 32'(bus.mux_sel_b), 0);
        chk("imm_sel_a", 32'(bus.mux_sel_a), 0);
        drive(mk(OP_LD, 5'd1, 5'd2, 5'd0), 1'b1);
        tick();
        drive(mk(c_ADDI, 5'd11, 5'd9, 5'd1), 1'b1);
        chk("imm_nostall", 32'(bus.stall), 0);
        tick();
        chk("imm_issue", 32'(bus.dec_valid), 1);
        idle2();

        // 5. Store does not shadow an earlier writer
        drive(mk(c_ADD, 5'd3, 5'd1, 5'd2), 1'b1);
        tick();
        drive(mk(OP_ST, 5'd3, 5'd2, 5'd0), 1'b1);
        tick();
        chk("st_mem_en", 32'(bus.mem_en_dec), 1);
        chk("st_rw",     32'(bus.mem_rw_dec), 1);
        chk("st_mux",    32'(bus.mem_mux_sel_dec), 0);
        drive(mk(c_ADD, 5'd8, 5'd3, 5'd1), 1'b1);
        tick();
        chk("st_sel_a", 32'(bus.mux_sel_a), 2);
        chk("st_sel_b", 32'(bus.mux_sel_b), 0);
        idle2();

        // 6. Register 0 handling
        drive(mk(c_ADD, 5'd0, 5'd1, 5'd2), 1'b1);
        tick();
        drive(mk(c_ADD, 5'd9, 5'd0, 5'd0), 1'b1);
        tick();
`ifdef ZERO_REG_EN
        chk("r0_sel_a", 32'(bus.mux_sel_a), 0);
        chk("r0_sel_b", 32'(bus.mux_sel_b), 0);
`else
        chk("r0_sel_a", 32'(bus.mux_sel_a), 1);
        chk("r0_sel_b", 32'(bus.mux_sel_b), 1);
`endif
        idle2();
        drive(mk(OP_LD, 5'd0, 5'd2, 5'd0), 1'b1);
        tick();
        drive(mk(c_ADD, 5'd9, 5'd0, 5'd1), 1'b1);
`ifdef ZERO_REG_EN
        chk("r0_stall", 32'(bus.stall), 0);
        tick();
        chk("r0_issue", 32'(bus.dec_valid), 1);
        chk("r0_ld_sel", 32'(bus.mux_sel_a), 0);
`else
        chk("r0_stall", 32'(bus.stall), 1);
        tick();
        chk("r0_bubble", 32'(bus.dec_valid), 0);
        tick();
        chk("r0_issue", 32'(bus.dec_valid), 1);
        chk("r0_ld_sel", 32'(bus.mux_sel_a), 2);
`endif
        idle2();

        // 7. Reset asserted during a stall
        drive(mk(OP_LD, 5'd6, 5'd1, 5'd0), 1'b1);
        tick();
        drive(mk(c_ADD, 5'd7, 5'd6, 5'd1), 1'b1);
        chk("rs_stall", 32'(bus.stall), 1);
        reset = 1'b1;
        #1;
        chk("rs_stall_drop", 32'(bus.stall), 0);
        chk("rs_ready",      32'(bus.ins_ready), 1);
        tick();
        chk("rs_valid",  32'(bus.dec_valid), 0);
        chk("rs_rw",     32'(bus.RW_dec), 0);
        chk("rs_mem_en", 32'(bus.mem_en_dec), 0);
        reset = 1'b0;
        #1;
        chk("rs_post_stall", 32'(bus.stall), 0);
        tick();
        chk("rs_issue", 32'(bus.dec_valid), 1);
        chk("rs_sel_a", 32'(bus.mux_sel_a), 0);
        chk("rs_rd",    32'(bus.RW_dec), 7);

        drive(20'h0, 1'b0);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
